// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the writeback path.
package cpu_pkg;
    localparam int XLEN          = 32;
    localparam int REG_W         = 5;
    localparam int WB_FIFO_DEPTH = 4;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_PIPE,
        SEL_FIFO
    } wb_sel_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its pipeline/long-latency clients.
interface wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
);
    logic            pipe_wr;
    reg_idx_t        pipe_rd;
    logic [XLEN-1:0] pipe_wd;
    logic            lu_valid;
    reg_idx_t        lu_rd;
    logic [XLEN-1:0] lu_wd;
    logic            lu_ready;
    reg_idx_t        q_rs1;
    reg_idx_t        q_rs2;
    logic            q_hit1;
    logic            q_hit2;
    logic            RFWr;
    reg_idx_t        wregnum;
    logic [XLEN-1:0] WD;

    modport slave (
        input  pipe_wr, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd, q_rs1, q_rs2,
        output lu_ready, q_hit1, q_hit2, RFWr, wregnum, WD
    );

    modport master (
        output pipe_wr, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd, q_rs1, q_rs2,
        input  lu_ready, q_hit1, q_hit2, RFWr, wregnum, WD
    );
endinterface

// File: rtl/wb_fifo.sv
// Long-latency result buffer: circular storage with per-entry live bits,
// kill-by-destination and combinational destination match queries.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int DEPTH = cpu_pkg::WB_FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  reg_idx_t        i_push_rd,
    input  logic [XLEN-1:0] i_push_wd,
    input  logic            i_pop,
    input  logic            i_kill,
    input  reg_idx_t        i_kill_rd,
    input  reg_idx_t        i_q_rs1,
    input  reg_idx_t        i_q_rs2,
    output reg_idx_t        o_head_rd,
    output logic [XLEN-1:0] o_head_wd,
    output logic            o_head_live,
    output logic [CW-1:0]   o_count,
    output logic            o_match1,
    output logic            o_match2
);
    reg_idx_t        r_rd [DEPTH];
    logic [XLEN-1:0] r_wd [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic w_push_live;

    // An entry enqueued alongside a killing pipeline write is born dead.
    assign w_push_live = (i_push_rd != '0) && !(i_kill && (i_push_rd == i_kill_rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_rd[i] == i_kill_rd)) r_live[i] <= 1'b0;
            end
            if (i_pop) begin
                r_live[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + PW'(1);
            end
            if (i_push) begin
                r_live[r_wptr] <= w_push_live;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd[r_wptr] <= i_push_rd;
            r_wd[r_wptr] <= i_push_wd;
        end
    end

    always_comb begin
        o_match1 = 1'b0;
        o_match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_rd[i] == i_q_rs1)) o_match1 = 1'b1;
            if (r_live[i] && (r_rd[i] == i_q_rs2)) o_match2 = 1'b1;
        end
    end

    assign o_head_rd   = r_rd[r_rptr];
    assign o_head_wd   = r_wd[r_rptr];
    assign o_head_live = r_live[r_rptr];
    assign o_count     = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the main pipeline always wins, buffered
// long-latency results drain in order when the pipeline is idle.
module wb_arbiter
    import cpu_pkg::*;
#(
    parameter int XLEN       = cpu_pkg::XLEN,
    parameter int FIFO_DEPTH = cpu_pkg::WB_FIFO_DEPTH,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    wb_arbiter_if.slave      bus
);
    logic            r_rfwr;
    reg_idx_t        r_wregnum;
    logic [XLEN-1:0] r_wd;

    logic            w_lu_ready;
    logic            w_accept;
    logic            w_pop;
    logic            w_kill;
    wb_sel_e         w_sel;
    reg_idx_t        w_head_rd;
    logic [XLEN-1:0] w_head_wd;
    logic            w_head_live;
    logic [CW-1:0]   w_count;
    logic            w_match1;
    logic            w_match2;

    assign w_lu_ready = !rst && (w_count < CW'(FIFO_DEPTH));
    assign w_accept   = bus.lu_valid && w_lu_ready;
    assign w_pop      = !bus.pipe_wr && (w_count != '0);
    assign w_kill     = bus.pipe_wr && (bus.pipe_rd != '0);

    always_comb begin
        w_sel = SEL_NONE;
        if (bus.pipe_wr)  w_sel = SEL_PIPE;
        else if (w_pop)   w_sel = SEL_FIFO;
    end

    wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_push_rd   (bus.lu_rd),
        .i_push_wd   (bus.lu_wd),
        .i_pop       (w_pop),
        .i_kill      (w_kill),
        .i_kill_rd   (bus.pipe_rd),
        .i_q_rs1     (bus.q_rs1),
        .i_q_rs2     (bus.q_rs2),
        .o_head_rd   (w_head_rd),
        .o_head_wd   (w_head_wd),
        .o_head_live (w_head_live),
        .o_count     (w_count),
        .o_match1    (w_match1),
        .o_match2    (w_match2)
    );

    // wregnum/WD only move on a real write so they hold their last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rfwr    <= 1'b0;
            r_wregnum <= '0;
            r_wd      <= '0;
        end else begin
            case (w_sel)
                SEL_PIPE: begin
                    r_rfwr <= (bus.pipe_rd != '0);
                    if (bus.pipe_rd != '0) begin
                        r_wregnum <= bus.pipe_rd;
                        r_wd      <= bus.pipe_wd;
                    end
                end
                SEL_FIFO: begin
                    r_rfwr <= w_head_live;
                    if (w_head_live) begin
                        r_wregnum <= w_head_rd;
                        r_wd      <= w_head_wd;
                    end
                end
                default: r_rfwr <= 1'b0;
            endcase
        end
    end

    assign bus.lu_ready = w_lu_ready;
    assign bus.RFWr     = r_rfwr;
    assign bus.wregnum  = r_wregnum;
    assign bus.WD       = r_wd;
    assign bus.q_hit1   = (bus.q_rs1 != '0) && (w_match1 || (r_rfwr && (r_wregnum == bus.q_rs1)));
    assign bus.q_hit2   = (bus.q_rs2 != '0) && (w_match2 || (r_rfwr && (r_wregnum == bus.q_rs2)));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued as
// stimulus is driven and matched by a monitor whenever RFWr fires.
module tb_wb_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        wr_t e;
        e.rd = rd;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    // Every RF write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.RFWr === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_wr observed=rd%0d/%0h expected=no_write", bus.wregnum, bus.WD);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_rd", 32'(bus.wregnum), 32'(e.rd));
                chk("wr_wd", bus.WD, e.wd);
            end
        end
    end

    initial begin
        bus.pipe_wr  = 1'b0;
        bus.pipe_rd  = '0;
        bus.pipe_wd  = '0;
        bus.lu_valid = 1'b0;
        bus.lu_rd    = '0;
        bus.lu_wd    = '0;
        bus.q_rs1    = '0;
        bus.q_rs2    = '0;

        // reset state
        #2;
        chk("rst_rfwr", 32'(bus.RFWr), 32'd0);
        chk("rst_ready", 32'(bus.lu_ready), 32'd0);
        chk("rst_wregnum", 32'(bus.wregnum), 32'd0);
        chk("rst_wd", bus.WD, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_ready", 32'(bus.lu_ready), 32'd1);
        chk("post_rst_rfwr", 32'(bus.RFWr), 32'd0);

        // pipeline write
        bus.pipe_wr = 1'b1;
        bus.pipe_rd = 5'd5;
        bus.pipe_wd = 32'h1234;
        expect_wr(5'd5, 32'h0000_1234);
        tick();
        bus.pipe_wr = 1'b0;
        settle();
        chk("pipe_rfwr", 32'(bus.RFWr), 32'd1);
        chk("pipe_wregnum", 32'(bus.wregnum), 32'd5);
        chk("pipe_wd", bus.WD, 32'h0000_1234);
        tick();
        chk("idle_rfwr", 32'(bus.RFWr), 32'd0);
        chk("idle_hold_wregnum", 32'(bus.wregnum), 32'd5);
        chk("idle_hold_wd", bus.WD, 32'h0000_1234);

        // single long-latency result, two-cycle latency
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd7;
        bus.lu_wd    = 32'hAA;
        settle();
        chk("lu_ready_idle", 32'(bus.lu_ready), 32'd1);
        expect_wr(5'd7, 32'hAA);
        tick();
        bus.lu_valid = 1'b0;
        bus.q_rs1    = 5'd7;
        settle();
        chk("lu_hit_buffered", 32'(bus.q_hit1), 32'd1);
        chk("lu_no_bypass", 32'(bus.RFWr), 32'd0);
        tick();
        chk("lu_rfwr", 32'(bus.RFWr), 32'd1);
        chk("lu_wregnum", 32'(bus.wregnum), 32'd7);
        chk("lu_wd", bus.WD, 32'hAA);
        chk("lu_hit_rfwr", 32'(bus.q_hit1), 32'd1);
        tick();
        chk("lu_done_rfwr", 32'(bus.RFWr), 32'd0);
        chk("lu_hit_clear", 32'(bus.q_hit1), 32'd0);

        // fill while pipeline blocks, then drain in order
        bus.pipe_wr = 1'b1;
        bus.pipe_rd = 5'd0;
        bus.pipe_wd = 32'hDEAD;
        for (int i = 1; i <= 4; i++) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(i);
            bus.lu_wd    = 32'h100 + 32'(i);
            settle();
            chk("fill_ready", 32'(bus.lu_ready), 32'd1);
            expect_wr(5'(i), 32'h100 + 32'(i));
            tick();
        end
        bus.lu_rd = 5'd30;
        bus.lu_wd = 32'hBAD;
        settle();
        chk("full_ready", 32'(bus.lu_ready), 32'd0);
        chk("full_rd0_rfwr", 32'(bus.RFWr), 32'd0);
        tick();
        bus.lu_valid = 1'b0;
        bus.pipe_wr  = 1'b0;
        settle();
        chk("full_ready_hold", 32'(bus.lu_ready), 32'd0);
        tick();
        chk("drain_ready", 32'(bus.lu_ready), 32'd1);
        chk("drain_rfwr_1", 32'(bus.RFWr), 32'd1);
        chk("drain_rd_1", 32'(bus.wregnum), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_rfwr", 32'(bus.RFWr), 32'd1);
            chk("drain_rd", 32'(bus.wregnum), 32'(i));
        end
        tick();
        chk("drain_done", 32'(bus.RFWr), 32'd0);

        // WAW kill of a buffered entry
        bus.pipe_wr  = 1'b1;
        bus.pipe_rd  = 5'd0;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd9;
        bus.lu_wd    = 32'h11;
        tick();
        bus.lu_valid = 1'b0;
        bus.pipe_rd  = 5'd9;
        bus.pipe_wd  = 32'h22;
        bus.q_rs2    = 5'd9;
        settle();
        chk("waw_hit_before", 32'(bus.q_hit2), 32'd1);
        expect_wr(5'd9, 32'h22);
        tick();
        bus.pipe_wr = 1'b0;
        settle();
        chk("waw_rfwr", 32'(bus.RFWr), 32'd1);
        chk("waw_wd", bus.WD, 32'h22);
        tick();
        chk("waw_dead_pop", 32'(bus.RFWr), 32'd0);
        chk("waw_hit_clear", 32'(bus.q_hit2), 32'd0);
        chk("waw_ready", 32'(bus.lu_ready), 32'd1);

        // WAW kill of an entry enqueued in the same cycle
        bus.pipe_wr  = 1'b1;
        bus.pipe_rd  = 5'd12;
        bus.pipe_wd  = 32'h44;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd12;
        bus.lu_wd    = 32'h33;
        expect_wr(5'd12, 32'h44);
        tick();
        bus.pipe_wr  = 1'b0;
        bus.lu_valid = 1'b0;
        bus.q_rs1    = 5'd12;
        settle();
        chk("waw_same_wd", bus.WD, 32'h44);
        tick();
        chk("waw_same_dead", 32'(bus.RFWr), 32'd0);
        chk("waw_same_hit", 32'(bus.q_hit1), 32'd0);

        // x0 destinations never write
        bus.pipe_wr  = 1'b1;
        bus.pipe_rd  = 5'd0;
        bus.pipe_wd  = 32'h99;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd0;
        bus.lu_wd    = 32'h55;
        bus.q_rs1    = 5'd0;
        settle();
        chk("x0_hit", 32'(bus.q_hit1), 32'd0);
        tick();
        bus.pipe_wr = 1'b0;
        bus.lu_wd   = 32'h66;
        tick();
        bus.lu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("x0_rfwr", 32'(bus.RFWr), 32'd0);
        end

        // reset with three entries buffered
        bus.pipe_wr = 1'b1;
        bus.pipe_rd = 5'd0;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(21 + i);
            bus.lu_wd    = 32'h300 + 32'(i);
            tick();
        end
        bus.lu_valid = 1'b0;
        bus.pipe_rd  = 5'd15;
        bus.pipe_wd  = 32'h77;
        bus.q_rs1    = 5'd21;
        settle();
        chk("pre_rst_hit", 32'(bus.q_hit1), 32'd1);
        tick();
        chk("pre_rst_rfwr", 32'(bus.RFWr), 32'd1);
        #2;
        rst          = 1'b1;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd25;
        bus.lu_wd    = 32'h1;
        #1;
        chk("mid_rst_rfwr", 32'(bus.RFWr), 32'd0);
        chk("mid_rst_wregnum", 32'(bus.wregnum), 32'd0);
        chk("mid_rst_wd", bus.WD, 32'd0);
        chk("mid_rst_ready", 32'(bus.lu_ready), 32'd0);
        chk("mid_rst_hit", 32'(bus.q_hit1), 32'd0);
        tick();
        tick();
        rst          = 1'b0;
        bus.pipe_wr  = 1'b0;
        bus.lu_valid = 1'b0;
        bus.q_rs1    = 5'd25;
        settle();
        chk("after_rst_ready", 32'(bus.lu_ready), 32'd1);
        chk("after_rst_drop", 32'(bus.q_hit1), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("after_rst_quiet", 32'(bus.RFWr), 32'd0);
        end

        // the buffer must again hold exactly four entries
        bus.pipe_wr = 1'b1;
        bus.pipe_rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            bus.lu_valid = 1'b1;
            bus.lu_rd    = 5'(16 + i);
            bus.lu_wd    = 32'h200 + 32'(i);
            settle();
            chk("refill_ready", 32'(bus.lu_ready), 32'd1);
            expect_wr(5'(16 + i), 32'h200 + 32'(i));
            tick();
        end
        bus.lu_valid = 1'b0;
        settle();
        chk("refill_full", 32'(bus.lu_ready), 32'd0);
        bus.pipe_wr = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
